// File: rtl/mult_8x8.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 multiplier accumulates the
// four nibble partial products over four cycles after a start request.
module mult_8x8 (
  input  logic        clk,
  input  logic        reset_a,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  input  logic        start,
  output logic [15:0] product8x8_out,
  output logic        done_flag
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CALC0 = 3'd1;
  localparam logic [2:0] CALC1 = 3'd2;
  localparam logic [2:0] CALC2 = 3'd3;
  localparam logic [2:0] CALC3 = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] prod_q, prod_d;
  logic        done_q, done_d;

  logic [3:0]  mul_a, mul_b;
  logic [3:0]  shamt;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;

  // Nibble selection for the shared multiplier, ordered lo*lo, hi*lo, lo*hi, hi*hi.
  always_comb begin
    mul_a = a_q[3:0];
    mul_b = b_q[3:0];
    shamt = 4'd0;
    case (state_q)
      CALC1: begin
        mul_a = a_q[7:4];
        shamt = 4'd4;
      end
      CALC2: begin
        mul_b = b_q[7:4];
        shamt = 4'd4;
      end
      CALC3: begin
        mul_a = a_q[7:4];
        mul_b = b_q[7:4];
        shamt = 4'd8;
      end
      default: ;
    endcase
  end

  assign pp         = {4'b0000, mul_a} * {4'b0000, mul_b};
  assign pp_shifted = {8'h00, pp} << shamt;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    done_d  = done_q;
    if (start) begin
      // A start in any state discards whatever was in flight.
      state_d = CALC0;
      a_d     = dataa;
      b_d     = datab;
      prod_d  = 16'h0000;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          prod_d = 16'h0000;
          done_d = 1'b0;
        end
        CALC0: begin
          prod_d  = prod_q + pp_shifted;
          state_d = CALC1;
        end
        CALC1: begin
          prod_d  = prod_q + pp_shifted;
          state_d = CALC2;
        end
        CALC2: begin
          prod_d  = prod_q + pp_shifted;
          state_d = CALC3;
        end
        CALC3: begin
          prod_d  = prod_q + pp_shifted;
          done_d  = 1'b1;
          state_d = DONE;
        end
        DONE: ;
        default: begin
          state_d = IDLE;
          prod_d  = 16'h0000;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      prod_q  <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign product8x8_out = prod_q;
  assign done_flag      = done_q;

endmodule

// File: tb/tb_mult_8x8.sv
// Scoreboard bench for mult_8x8: stimulus pushes expected products with their
// due cycle; a negedge monitor pops and compares whenever done_flag rises.
module tb_mult_8x8;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product8x8_out;
  logic        done_flag;

  mult_8x8 dut (
    .clk            (clk),
    .reset_a        (reset_a),
    .dataa          (dataa),
    .datab          (datab),
    .start          (start),
    .product8x8_out (product8x8_out),
    .done_flag      (done_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] prod;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  logic        prev_done = 1'b0;
  logic [15:0] held = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on each rising done_flag, check the result holds while done stays high.
  always @(negedge clk) begin
    if (done_flag === 1'b1 && prev_done !== 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, done_flag}, 32'd0);
      end else begin
        cur = sb.pop_front();
        check("product", {16'd0, product8x8_out}, {16'd0, cur.prod});
        check("latency", cyc, cur.due);
        held = cur.prod;
      end
    end else if (done_flag === 1'b1) begin
      check("hold", {16'd0, product8x8_out}, {16'd0, held});
    end
    if (sb.size() > 0 && cyc > sb[0].due) begin
      total++;
      bad++;
      $display("FAIL timeout: no done for expected %0d due at cycle %0d (now %0d)",
               sb[0].prod, sb[0].due, cyc);
      void'(sb.pop_front());
    end
    prev_done <= done_flag;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold start for 'hold' edges; only the operands on the last start edge count.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input int hold, input bit push);
    exp_t e;
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      dataa = (i == hold - 1) ? a : 8'($urandom);
      datab = (i == hold - 1) ? b : 8'($urandom);
      step();
      check("start_prod0", {16'd0, product8x8_out}, 32'd0);
      check("start_done0", {31'd0, done_flag}, 32'd0);
    end
    if (push) begin
      e.prod = 16'(int'(a) * int'(b));
      e.due  = cyc + 4;
      sb.push_back(e);
    end
    start = 1'b0;
    dataa = 8'($urandom);
    datab = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int hold;
    reset_a = 1'b1;
    start   = 1'b0;
    dataa   = 8'd0;
    datab   = 8'd0;
    idle(2);
    check("reset_prod", {16'd0, product8x8_out}, 32'd0);
    check("reset_done", {31'd0, done_flag}, 32'd0);
    reset_a = 1'b0;
    idle(3);
    check("idle_prod", {16'd0, product8x8_out}, 32'd0);
    check("idle_done", {31'd0, done_flag}, 32'd0);

    issue(8'd17, 8'd100, 1, 1'b1);
    idle(8);
    check("held_1700", {16'd0, product8x8_out}, 32'd1700);
    check("held_done", {31'd0, done_flag}, 32'd1);

    issue(8'd94, 8'd57, 1, 1'b1);   idle(5);
    issue(8'd255, 8'd255, 1, 1'b1); idle(5);
    issue(8'd32, 8'd232, 1, 1'b1);  idle(5);

    // Restart two edges into a calculation.
    issue(8'd255, 8'd255, 1, 1'b0);
    idle(1);
    issue(8'd14, 8'd7, 1, 1'b1);
    idle(6);

    issue(8'd26, 8'd100, 3, 1'b1);  idle(6);
    issue(8'd0, 8'd200, 1, 1'b1);   idle(5);
    issue(8'd200, 8'd1, 1, 1'b1);   idle(5);

    // Reset while in CALC2.
    issue(8'd99, 8'd99, 1, 1'b0);
    idle(2);
    reset_a = 1'b1;
    step();
    check("rst_calc_prod", {16'd0, product8x8_out}, 32'd0);
    check("rst_calc_done", {31'd0, done_flag}, 32'd0);
    reset_a = 1'b0;
    idle(6);
    check("rst_stay_prod", {16'd0, product8x8_out}, 32'd0);
    check("rst_stay_done", {31'd0, done_flag}, 32'd0);

    // Reset and start together.
    reset_a = 1'b1;
    start   = 1'b1;
    dataa   = 8'd50;
    datab   = 8'd50;
    step();
    check("rst_win_prod", {16'd0, product8x8_out}, 32'd0);
    check("rst_win_done", {31'd0, done_flag}, 32'd0);
    reset_a = 1'b0;
    start   = 1'b0;
    idle(6);
    check("rst_win_idle", {31'd0, done_flag}, 32'd0);

    // Random traffic: a gap under four idle edges aborts the transaction.
    for (int t = 0; t < 40; t++) begin
      gap  = (t == 39) ? 6 : int'($urandom_range(0, 7));
      hold = int'($urandom_range(1, 2));
      issue(8'($urandom), 8'($urandom), hold, gap >= 4);
      idle(gap);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
